// File: rtl/amber_wb_responder.sv
// Wishbone responder for the Amber core's 128-bit bus. Instruction fetches
// (adr[31] = 0) are served from a bench-fed instruction FIFO padded with NOP
// lanes; data accesses (adr[31] = 1) hit a byte-writable line RAM. Each
// completed data write is echoed on the store-capture port.
module amber_wb_responder #(
    parameter int unsigned MEM_LINES   = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] NOP_WORD    = 32'hF0801003
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [31:0]                 i_wb_adr,
    input  logic [15:0]                 i_wb_sel,
    input  logic                        i_wb_we,
    input  logic [127:0]                i_wb_dat,
    input  logic                        i_wb_cyc,
    input  logic                        i_wb_stb,
    output logic [127:0]                o_wb_dat,
    output logic                        o_wb_ack,
    output logic                        o_wb_err,
    input  logic                        i_inst_valid,
    input  logic [31:0]                 i_inst,
    output logic                        o_inst_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        o_st_valid,
    output logic [31:0]                 o_st_adr,
    output logic [127:0]                o_st_data,
    output logic [15:0]                 o_st_sel
);
    localparam int unsigned LineW = $clog2(MEM_LINES);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e         state_q, state_d;
    logic [31:0]    adr_q, adr_d;
    logic [15:0]    sel_q, sel_d;
    logic           we_q, we_d;
    logic [127:0]   dat_q, dat_d;
    logic [3:0]     wait_q, wait_d;
    logic           enter_resp;

    logic [127:0]   mem [MEM_LINES];
    logic [31:0]    fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic           push, pop, fifo_empty;

    logic [31:0]    req_adr;
    logic           req_we;
    logic [15:0]    req_sel;
    logic [127:0]   req_dat;
    logic           req_inst, req_bad, req_wr_ok;
    logic [LineW-1:0] req_line;
    logic [127:0]   resp_dat;

    assign fifo_empty   = (count_q == '0);
    assign push         = i_inst_valid && o_inst_ready;
    assign pop          = (state_q == StResp) && !adr_q[31] && !we_q && !fifo_empty;
    assign o_fifo_count = count_q;

    // Decode the request being answered: the live bus in IDLE, the latched copy later
    always_comb begin
        if (state_q == StIdle) begin
            req_adr = i_wb_adr;
            req_we  = i_wb_we;
            req_sel = i_wb_sel;
            req_dat = i_wb_dat;
        end else begin
            req_adr = adr_q;
            req_we  = we_q;
            req_sel = sel_q;
            req_dat = dat_q;
        end
        req_inst  = !req_adr[31] && !req_we;
        req_bad   = req_adr[31] ? (req_adr[30:LineW+4] != '0) : req_we;
        req_wr_ok = req_adr[31] && req_we && !req_bad;
        req_line  = req_adr[LineW+3:4];
        if (req_bad || req_we) begin
            resp_dat = '0;
        end else if (req_inst) begin
            resp_dat = {NOP_WORD, NOP_WORD, NOP_WORD, fifo_mem[rd_ptr_q]};
        end else begin
            resp_dat = mem[req_line];
        end
    end

    // Next-state logic: accept, count wait states, stall fetches on an empty FIFO
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        we_d       = we_q;
        dat_d      = dat_q;
        wait_d     = wait_q;
        enter_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_wb_cyc && i_wb_stb) begin
                    adr_d  = i_wb_adr;
                    sel_d  = i_wb_sel;
                    we_d   = i_wb_we;
                    dat_d  = i_wb_dat;
                    wait_d = 4'(WAIT_STATES);
                    // A fetch with nothing queued must stall in WAIT even with zero wait states
                    if (WAIT_STATES == 0 && !(req_inst && fifo_empty)) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!i_wb_cyc) begin
                    state_d = StIdle;
                end else begin
                    if (wait_q != 4'd0) begin
                        wait_d = wait_q - 4'd1;
                    end
                    if (wait_q <= 4'd1 && !(req_inst && fifo_empty)) begin
                        enter_resp = 1'b1;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (enter_resp) begin
            state_d = StResp;
        end
    end

    // FSM state and latched request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            wait_q  <= wait_d;
        end
    end

    // Registered bus response and store capture, updated only on entry to RESP
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wb_dat   <= '0;
            o_wb_ack   <= 1'b0;
            o_wb_err   <= 1'b0;
            o_st_valid <= 1'b0;
            o_st_adr   <= '0;
            o_st_data  <= '0;
            o_st_sel   <= '0;
        end else begin
            o_wb_ack   <= enter_resp && !req_bad;
            o_wb_err   <= enter_resp && req_bad;
            o_st_valid <= enter_resp && req_wr_ok;
            if (enter_resp) begin
                o_wb_dat <= resp_dat;
            end
            if (enter_resp && req_wr_ok) begin
                o_st_adr  <= req_adr;
                o_st_data <= req_dat;
                o_st_sel  <= req_sel;
            end
        end
    end

    // Line RAM byte-lane write, committed together with the ack; contents not reset
    always_ff @(posedge i_clk) begin
        if (enter_resp && req_wr_ok && !i_rst) begin
            for (int b = 0; b < 16; b++) begin
                if (req_sel[b]) begin
                    mem[req_line][8*b +: 8] <= req_dat[8*b +: 8];
                end
            end
        end
    end

    // Instruction FIFO storage
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_inst;
        end
    end

    // FIFO occupancy: combined push and pop leaves the count unchanged
    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, count and registered ready flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            o_inst_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q      <= count_d;
            o_inst_ready <= (count_d != CntW'(FIFO_DEPTH));
        end
    end
endmodule

// File: tb/tb_amber_wb_responder.sv
// Randomised self-checking bench for amber_wb_responder against a queue/array model.
module tb_amber_wb_responder;
    localparam int unsigned MEM_LINES = 256;
    localparam int unsigned WS        = 1;
    localparam int unsigned DEPTH     = 8;
    localparam logic [31:0] NOP       = 32'hF0801003;

    logic         i_clk, i_rst;
    logic [31:0]  i_wb_adr;
    logic [15:0]  i_wb_sel;
    logic         i_wb_we;
    logic [127:0] i_wb_dat;
    logic         i_wb_cyc, i_wb_stb;
    logic [127:0] o_wb_dat;
    logic         o_wb_ack, o_wb_err;
    logic         i_inst_valid;
    logic [31:0]  i_inst;
    logic         o_inst_ready;
    logic [3:0]   o_fifo_count;
    logic         o_st_valid;
    logic [31:0]  o_st_adr;
    logic [127:0] o_st_data;
    logic [15:0]  o_st_sel;

    amber_wb_responder #(
        .MEM_LINES(MEM_LINES), .WAIT_STATES(WS), .FIFO_DEPTH(DEPTH), .NOP_WORD(NOP)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
        .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .i_inst_valid(i_inst_valid), .i_inst(i_inst), .o_inst_ready(o_inst_ready),
        .o_fifo_count(o_fifo_count),
        .o_st_valid(o_st_valid), .o_st_adr(o_st_adr), .o_st_data(o_st_data),
        .o_st_sel(o_st_sel)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc_n = 0;
    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model
    logic [31:0]  mq[$];
    logic [127:0] ref_mem [MEM_LINES];

    // Results of the last bus transaction
    logic         r_ack, r_err, r_tail;
    logic [127:0] r_dat;
    int           r_lat, r_ack_edge, r_st_cnt, r_push_edge;
    logic [31:0]  r_st_adr;
    logic [127:0] r_st_data;
    logic [15:0]  r_st_sel;

    task automatic ref_access(input logic [31:0] adr, input logic we, input logic [15:0] sel,
                              input logic [127:0] dat, output logic e_err,
                              output logic [127:0] e_dat, output logic e_st);
        int unsigned off, line;
        e_err = 1'b0;
        e_dat = '0;
        e_st  = 1'b0;
        if (!adr[31]) begin
            if (we) begin
                e_err = 1'b1;
            end else if (mq.size() > 0) begin
                e_dat = {NOP, NOP, NOP, mq[0]};
                void'(mq.pop_front());
            end
        end else begin
            off = adr & 32'h7FFF_FFFF;
            if (off >= MEM_LINES * 16) begin
                e_err = 1'b1;
            end else begin
                line = off / 16;
                if (we) begin
                    for (int b = 0; b < 16; b++)
                        if (sel[b]) ref_mem[line][8*b +: 8] = dat[8*b +: 8];
                    e_st = 1'b1;
                end else begin
                    e_dat = ref_mem[line];
                end
            end
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        @(posedge i_clk); #1;
        i_inst_valid = 1'b1;
        i_inst       = w;
        @(posedge i_clk); #1;
        r_push_edge  = cyc_n;
        i_inst_valid = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(w);
    endtask

    task automatic wb_txn(input logic [31:0] adr, input logic we, input logic [15:0] sel,
                          input logic [127:0] dat);
        r_ack = 0; r_err = 0; r_dat = '0; r_lat = 0; r_st_cnt = 0; r_tail = 0; r_ack_edge = 0;
        @(posedge i_clk); #1;
        i_wb_adr = adr; i_wb_we = we; i_wb_sel = sel; i_wb_dat = dat;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_st_valid) begin
                r_st_cnt++;
                r_st_adr = o_st_adr; r_st_data = o_st_data; r_st_sel = o_st_sel;
            end
            if (o_wb_ack || o_wb_err) begin
                r_ack = o_wb_ack; r_err = o_wb_err; r_dat = o_wb_dat;
                r_lat = k; r_ack_edge = cyc_n;
                break;
            end
        end
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        @(negedge i_clk);
        r_tail = o_wb_ack || o_wb_err || o_st_valid;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge i_clk);
        n_cmp++; if (o_wb_dat !== 128'h0 || o_wb_ack !== 1'b0 || o_wb_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus: dat=%h ack=%b err=%b want 0", o_wb_dat, o_wb_ack, o_wb_err); end
        n_cmp++; if ({o_st_valid, o_st_adr, o_st_data, o_st_sel} !== '0) begin
            n_fail++; $display("FAIL reset_st: v=%b adr=%h sel=%h want 0", o_st_valid, o_st_adr, o_st_sel); end
        n_cmp++; if (o_fifo_count !== 4'd0 || o_inst_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_fifo: count=%0d ready=%b want 0/1", o_fifo_count, o_inst_ready); end
        @(posedge i_clk); #1 i_rst = 1'b0;
    endtask

    task automatic test_inst_read;
        logic e_err, e_st; logic [127:0] e_dat;
        push_word(32'hE3A01005);
        n_cmp++; if (o_fifo_count !== 4'd1) begin
            n_fail++; $display("FAIL ifetch_count_pre: got %0d want 1", o_fifo_count); end
        ref_access(32'h0, 1'b0, 16'hFFFF, '0, e_err, e_dat, e_st);
        wb_txn(32'h0, 1'b0, 16'hFFFF, '0);
        n_cmp++; if (r_ack !== 1'b1 || r_err !== 1'b0) begin
            n_fail++; $display("FAIL ifetch_ack: ack=%b err=%b want 1/0", r_ack, r_err); end
        n_cmp++; if (r_lat !== 1 + WS) begin
            n_fail++; $display("FAIL ifetch_latency: got %0d want %0d", r_lat, 1 + WS); end
        n_cmp++; if (r_dat !== {96'hF0801003F0801003F0801003, 32'hE3A01005} || r_dat !== e_dat) begin
            n_fail++; $display("FAIL ifetch_data: got %h want %h", r_dat, e_dat); end
        n_cmp++; if (o_fifo_count !== 4'd0 || r_tail !== 1'b0) begin
            n_fail++; $display("FAIL ifetch_pop: count=%0d tail=%b want 0/0", o_fifo_count, r_tail); end
    endtask

    task automatic test_stall;
        fork
            wb_txn(32'h0, 1'b0, 16'hFFFF, '0);
            begin
                repeat (3) @(posedge i_clk);
                push_word(32'hE0812002);
            end
        join
        void'(mq.pop_front());
        n_cmp++; if (r_ack !== 1'b1 || r_dat !== {NOP, NOP, NOP, 32'hE0812002}) begin
            n_fail++; $display("FAIL stall_data: ack=%b dat=%h want lane0 E0812002", r_ack, r_dat); end
        n_cmp++; if (r_ack_edge !== r_push_edge + 1) begin
            n_fail++; $display("FAIL stall_timing: ack edge %0d want %0d", r_ack_edge, r_push_edge + 1); end
        n_cmp++; if (o_fifo_count !== 4'd0) begin
            n_fail++; $display("FAIL stall_pop: count %0d want 0", o_fifo_count); end
    endtask

    task automatic test_write_readback;
        logic e_err, e_st; logic [127:0] e_dat;
        ref_access(32'h8000_0010, 1'b1, 16'hFFFF, {16{8'h11}}, e_err, e_dat, e_st);
        wb_txn(32'h8000_0010, 1'b1, 16'hFFFF, {16{8'h11}});
        ref_access(32'h8000_0010, 1'b1, 16'h000F, {4{32'hDEADBEEF}}, e_err, e_dat, e_st);
        wb_txn(32'h8000_0010, 1'b1, 16'h000F, {4{32'hDEADBEEF}});
        n_cmp++; if (r_ack !== 1'b1 || r_err !== 1'b0 || r_st_cnt !== 1 || r_tail !== 1'b0) begin
            n_fail++; $display("FAIL wr_ack: ack=%b err=%b st=%0d tail=%b want 1/0/1/0", r_ack, r_err, r_st_cnt, r_tail); end
        n_cmp++; if (r_st_adr !== 32'h8000_0010 || r_st_sel !== 16'h000F || r_st_data !== {4{32'hDEADBEEF}}) begin
            n_fail++; $display("FAIL wr_capture: adr=%h sel=%h data=%h", r_st_adr, r_st_sel, r_st_data); end
        wb_txn(32'h8000_0010, 1'b0, 16'hFFFF, '0);
        n_cmp++; if (r_dat !== {{12{8'h11}}, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL wr_readback: got %h want %h", r_dat, {{12{8'h11}}, 32'hDEADBEEF}); end
        // Zero byte enables: acked and captured, RAM unchanged
        wb_txn(32'h8000_0010, 1'b1, 16'h0000, {4{32'h01234567}});
        n_cmp++; if (r_ack !== 1'b1 || r_st_cnt !== 1 || r_st_sel !== 16'h0) begin
            n_fail++; $display("FAIL wr_sel0: ack=%b st=%0d sel=%h want 1/1/0", r_ack, r_st_cnt, r_st_sel); end
        ref_access(32'h8000_0010, 1'b0, 16'hFFFF, '0, e_err, e_dat, e_st);
        wb_txn(32'h8000_0010, 1'b0, 16'hFFFF, '0);
        n_cmp++; if (r_dat !== e_dat) begin
            n_fail++; $display("FAIL wr_sel0_readback: got %h want %h", r_dat, e_dat); end
    endtask

    task automatic test_errors;
        logic e_err, e_st; logic [127:0] e_dat;
        push_word(32'hA5A5_0001);
        wb_txn(32'h0000_0040, 1'b1, 16'hFFFF, {4{32'hCAFEF00D}});
        n_cmp++; if (r_err !== 1'b1 || r_ack !== 1'b0 || r_st_cnt !== 0) begin
            n_fail++; $display("FAIL err_iwrite: err=%b ack=%b st=%0d want 1/0/0", r_err, r_ack, r_st_cnt); end
        n_cmp++; if (o_fifo_count !== 4'd1) begin
            n_fail++; $display("FAIL err_iwrite_fifo: count %0d want 1", o_fifo_count); end
        ref_access(32'h0000_0040, 1'b0, 16'hFFFF, '0, e_err, e_dat, e_st);
        wb_txn(32'h0000_0040, 1'b0, 16'hFFFF, '0);
        n_cmp++; if (r_ack !== 1'b1 || r_dat !== e_dat) begin
            n_fail++; $display("FAIL err_drain: ack=%b dat=%h want %h", r_ack, r_dat, e_dat); end
        wb_txn(32'h8001_0000, 1'b0, 16'hFFFF, '0);
        n_cmp++; if (r_err !== 1'b1 || r_ack !== 1'b0 || r_dat !== 128'h0) begin
            n_fail++; $display("FAIL err_range: err=%b ack=%b dat=%h want 1/0/0", r_err, r_ack, r_dat); end
    endtask

    task automatic test_abort;
        logic e_err, e_st; logic [127:0] e_dat;
        logic seen;
        ref_access(32'h8000_0020, 1'b1, 16'hFFFF, {4{32'h5555AAAA}}, e_err, e_dat, e_st);
        wb_txn(32'h8000_0020, 1'b1, 16'hFFFF, {4{32'h5555AAAA}});
        // Drop cyc while waiting
        seen = 1'b0;
        @(posedge i_clk); #1;
        i_wb_adr = 32'h8000_0020; i_wb_we = 1'b1; i_wb_sel = 16'hFFFF; i_wb_dat = '1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        @(posedge i_clk); #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        repeat (6) begin @(negedge i_clk); seen |= o_wb_ack | o_wb_err | o_st_valid; end
        n_cmp++; if (seen !== 1'b0) begin
            n_fail++; $display("FAIL abort_cyc: response seen=%b want 0", seen); end
        ref_access(32'h8000_0020, 1'b0, 16'hFFFF, '0, e_err, e_dat, e_st);
        wb_txn(32'h8000_0020, 1'b0, 16'hFFFF, '0);
        n_cmp++; if (r_dat !== e_dat) begin
            n_fail++; $display("FAIL abort_cyc_ram: got %h want %h", r_dat, e_dat); end
        // Reset while waiting; FIFO holds one word that reset must flush
        push_word(32'h1234_5678);
        seen = 1'b0;
        @(posedge i_clk); #1;
        i_wb_adr = 32'h8000_0020; i_wb_we = 1'b1; i_wb_sel = 16'hFFFF; i_wb_dat = '0;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        repeat (2) begin @(negedge i_clk); seen |= o_wb_ack | o_wb_err | o_st_valid; end
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        @(posedge i_clk); #1 i_rst = 1'b0;
        mq.delete();
        repeat (3) begin @(negedge i_clk); seen |= o_wb_ack | o_wb_err | o_st_valid; end
        n_cmp++; if (seen !== 1'b0) begin
            n_fail++; $display("FAIL abort_rst: response seen=%b want 0", seen); end
        n_cmp++; if (o_wb_dat !== 128'h0 || {o_st_adr, o_st_data, o_st_sel} !== '0) begin
            n_fail++; $display("FAIL abort_rst_outs: dat=%h st_adr=%h want 0", o_wb_dat, o_st_adr); end
        n_cmp++; if (o_fifo_count !== 4'd0 || o_inst_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_rst_fifo: count=%0d ready=%b want 0/1", o_fifo_count, o_inst_ready); end
        ref_access(32'h8000_0020, 1'b0, 16'hFFFF, '0, e_err, e_dat, e_st);
        wb_txn(32'h8000_0020, 1'b0, 16'hFFFF, '0);
        n_cmp++; if (r_dat !== e_dat) begin
            n_fail++; $display("FAIL abort_rst_ram: got %h want %h", r_dat, e_dat); end
    endtask

    task automatic test_fifo_full;
        logic e_err, e_st; logic [127:0] e_dat;
        logic [31:0] w;
        for (int i = 0; i < 9; i++) begin
            push_word($urandom);
            n_cmp++; if (o_inst_ready !== (mq.size() < DEPTH) || o_fifo_count !== 4'(mq.size())) begin
                n_fail++; $display("FAIL full_push%0d: ready=%b count=%0d want %b/%0d", i, o_inst_ready,
                                   o_fifo_count, mq.size() < DEPTH, mq.size()); end
        end
        ref_access(32'h0, 1'b0, 16'hFFFF, '0, e_err, e_dat, e_st);
        wb_txn(32'h0, 1'b0, 16'hFFFF, '0);
        n_cmp++; if (r_dat !== e_dat || o_fifo_count !== 4'd7 || o_inst_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_pop: dat=%h count=%0d ready=%b want %h/7/1", r_dat,
                               o_fifo_count, o_inst_ready, e_dat); end
        // Push landing on the pop edge
        w = $urandom;
        ref_access(32'h0, 1'b0, 16'hFFFF, '0, e_err, e_dat, e_st);
        fork
            wb_txn(32'h0, 1'b0, 16'hFFFF, '0);
            begin
                for (int k = 0; k < 100; k++) begin @(negedge i_clk); if (o_wb_ack) break; end
                i_inst_valid = 1'b1; i_inst = w;
                @(posedge i_clk); #1 i_inst_valid = 1'b0;
            end
        join
        mq.push_back(w);
        n_cmp++; if (r_dat !== e_dat || o_fifo_count !== 4'(mq.size())) begin
            n_fail++; $display("FAIL push_pop: dat=%h count=%0d want %h/%0d", r_dat, o_fifo_count,
                               e_dat, mq.size()); end
        while (mq.size() > 0) begin
            ref_access(32'h0, 1'b0, 16'hFFFF, '0, e_err, e_dat, e_st);
            wb_txn(32'h0, 1'b0, 16'hFFFF, '0);
            n_cmp++; if (r_dat !== e_dat || o_fifo_count !== 4'(mq.size())) begin
                n_fail++; $display("FAIL drain: dat=%h count=%0d want %h/%0d", r_dat, o_fifo_count,
                                   e_dat, mq.size()); end
        end
    endtask

    task automatic test_random;
        logic e_err, e_st; logic [127:0] e_dat;
        logic [31:0] adr; logic we; logic [15:0] sel; logic [127:0] dat;
        int kind;
        for (int l = 0; l < 16; l++) begin
            dat = {$urandom, $urandom, $urandom, $urandom};
            adr = 32'h8000_0000 | (l << 4);
            ref_access(adr, 1'b1, 16'hFFFF, dat, e_err, e_dat, e_st);
            wb_txn(adr, 1'b1, 16'hFFFF, dat);
            n_cmp++; if (r_ack !== 1'b1 || r_st_cnt !== 1) begin
                n_fail++; $display("FAIL init_line%0d: ack=%b st=%0d want 1/1", l, r_ack, r_st_cnt); end
        end
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            sel  = 16'($urandom);
            dat  = {$urandom, $urandom, $urandom, $urandom};
            we   = 1'($urandom);
            if (kind < 7) begin
                adr = 32'h8000_0000 | ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
            end else if (kind == 7) begin
                adr = 32'h8000_0000 | ($urandom_range(1, 32'h7FFFF) << 12) | $urandom_range(0, 4095);
            end else begin
                adr = $urandom_range(0, 32'h7FFF_FFFF);
                if (!we) push_word($urandom);
            end
            ref_access(adr, we, sel, dat, e_err, e_dat, e_st);
            wb_txn(adr, we, sel, dat);
            n_cmp++; if (r_ack !== !e_err || r_err !== e_err || r_st_cnt !== int'(e_st)) begin
                n_fail++; $display("FAIL rnd%0d_resp adr=%h we=%b: ack=%b err=%b st=%0d want %b/%b/%0d",
                                   i, adr, we, r_ack, r_err, r_st_cnt, !e_err, e_err, e_st); end
            if (!we) begin
                n_cmp++; if (r_dat !== e_dat) begin
                    n_fail++; $display("FAIL rnd%0d_data adr=%h: got %h want %h", i, adr, r_dat, e_dat); end
            end
            if (e_st) begin
                n_cmp++; if (r_st_adr !== adr || r_st_sel !== sel || r_st_data !== dat) begin
                    n_fail++; $display("FAIL rnd%0d_capture: adr=%h sel=%h want %h/%h", i, r_st_adr,
                                       r_st_sel, adr, sel); end
            end
            n_cmp++; if (o_fifo_count !== 4'(mq.size())) begin
                n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", i, o_fifo_count, mq.size()); end
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_wb_adr = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_dat = '0;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_inst_valid = 1'b0; i_inst = '0;
        test_reset();
        test_inst_read();
        test_stall();
        test_write_readback();
        test_errors();
        test_abort();
        test_fifo_full();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "time limit");
    end
endmodule
